can_node_monitor: RTL
=====================

# can_node_monitor

Parametrised status/display block for NCH CAN controller channels. It snapshots each channel's received payload on the rx_ready rising edge and keeps per-channel saturating frame counters and sticky activity flags. Results are paged three channels at a time onto the four 128-bit OLED text lines and the LED bank, with debounced button control. It sits at board top level between the can_controller instances and the OLED/LED drivers, and replaces hand-wired per-channel display logic.

## Interface
- NCH, 2: channel count, 1..8
- DW, 108: payload width per channel, 1..128
- TICK, 100: GCLK cycles per display refresh, ≥2
- DEB, 1000: GCLK cycles a button must be stable to register, ≥2
- GCLK  in  1  system clock, all logic rising-edge
- RES  in  1  asynchronous, active-low reset
- DOUT  in  NCH*DW  channel payloads; channel i at [i*DW +: DW]
- rx_ready  in  NCH  per-channel receive-done level
- BTNU  in  1  page up, raw/asynchronous
- BTND  in  1  page down, raw/asynchronous
- BTNC  in  1  clear counters and flags, raw/asynchronous
- OLED_S0..OLED_S3  out  128 each  16-char ASCII lines, MSB = leftmost char
- LD  out  8  activity LEDs

## Operation
- Pages: NPG = ceil(NCH/3). Page register pg is 0..NPG-1. Page p shows channels 3p, 3p+1, 3p+2.
- Buttons: each button passes through a 2-FF synchroniser and then a debouncer. The debouncer's stable state changes only after DEB consecutive equal samples. A 0→1 change of the stable state emits a 1-cycle pulse.
- BTNU pulse: pg ← (pg+1) mod NPG. BTND pulse: pg ← pg-1, wrapping 0 → NPG-1. Up and down pulses in the same cycle: pg unchanged.
- Edge detect: rx_q registers rx_ready. rise[i] = rx_ready[i] & ~rx_q[i].
- On rise[i]:
  - snap[i] ← DOUT channel i
  - cnt[i] ← cnt[i]+1, saturating at 8'hFF
  - act[i] ← 1
- BTNC pulse: all cnt ← 0 and all act ← 0. Snapshots are kept. A clear and a rise in the same cycle give cnt = 1 and act = 1 (the rise wins after the clear).
- Display refresh: a tick counter runs 0..TICK-1 and tick is asserted when it reaches TICK-1. On tick, all four OLED lines and LD load from current state. Between ticks they hold their values.
  - OLED_S0 = "P", digit(pg+1), "/", digit(NPG), " ", then for k = 0..2: two uppercase hex chars of cnt[3pg+k] followed by a space, then padding spaces to 16 chars. Example: "P1/1 0A 03 --   ".
  - A channel index ≥ NCH renders as "--".
  - OLED_S(k+1), k = 0..2: {(128-DW) zero bits, snap[3pg+k]}. A channel index ≥ NCH gives 16 ASCII spaces.
  - LD[i] = act[i] for i < NCH; LD[i] = 0 for i ≥ NCH.

## Timing
- Reset (RES low, asynchronous):
  - OLED_S0..S3 = 16 spaces (128'h2020…20)
  - LD = 0
  - pg, cnt, act, snap, rx_q and the tick counter = 0
  - debouncer stable states = 0
  - The first tick occurs TICK cycles after RES deasserts.
- rx_ready rising edge sampled at edge t: snap, cnt and act are updated at edge t+1. They appear on the outputs at the first tick at or after t+1.
- Button press: pulse emitted 2 (sync) + DEB cycles after a clean rising edge. A bounce shorter than DEB cycles produces no pulse. Holding a button produces exactly one pulse.
- A page change is visible at the next tick. No output changes mid-line between ticks.
- rx_ready held high produces one count only. A new count requires rx_ready to fall and rise again.
- RES asserted mid-operation clears all state immediately. Outputs go to their reset values in the same cycle, without waiting for a tick.

## Structure
- Package can_mon_pkg holds:
  - LPP = 3 (channels per page)
  - ASCII_SP = 8'h20
  - the 16-space line constant
  - function hex2ascii(4-bit) → 8-bit
  - function digit(0..9) → ASCII
- Sub-module btn_debounce (params DEB; ports GCLK, RES, din, pulse), instantiated three times.
- Per-channel state (snap, cnt, act, rx_q) lives in generate loops. The page mux and line formatting are combinational, feeding the tick-gated output registers.

## Test plan
- Reset then idle, NCH=2, TICK=10: after the first tick, S0 = "P1/1 00 00 --   ", S1 = 0, S2 = 0, S3 = 16 spaces, LD = 0.
- Channel 1 DOUT = "LOL", one rx_ready pulse: after the next tick, S2 = {20'd0,"LOL"}, S0 counts show "00 01", LD = 8'h02.
- NCH=8: 256 rx pulses on channel 0 → cnt stays 8'hFF ("FF"). BTNU×3 gives pages P2/3, P3/3, P1/3. BTND from P1/3 gives P3/3, with S3 = spaces (channel 8 absent).
- Bounce: BTNU toggling every DEB/2 cycles for 5·DEB cycles, then stable high → exactly one page increment.
- BTNC pulse coinciding with a channel 0 rise → cnt[0] = 1 and LD[0] = 1. Other channels' counts = 0. Snapshots unchanged.
- Assert RES between ticks with nonzero state → outputs are spaces/0 in the same cycle. After release, page = P1.

Source files
------------

// File: rtl/can_node_monitor_pkg.sv
// ============================================================================
// can_mon_pkg : shared constants and ASCII helpers for can_node_monitor
// Revision 1.0
// ============================================================================
`default_nettype none

package can_mon_pkg;

   localparam int           LPP      = 3;
   localparam logic [7:0]   ASCII_SP = 8'h20;
   localparam logic [7:0]   ASCII_DASH = 8'h2D;
   localparam logic [127:0] LINE_SP  = {16{ASCII_SP}};

   function automatic logic [7:0] hex2ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
   endfunction

   function automatic logic [7:0] digit(input logic [3:0] d);
      return 8'h30 + {4'd0, d};
   endfunction

endpackage

`default_nettype wire

// File: rtl/can_node_monitor_if.sv
// ============================================================================
// can_node_monitor_if : channel payload / button / display bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface can_node_monitor_if #(
   parameter int NCH = 2,
   parameter int DW  = 108
);
   logic [NCH*DW-1:0] DOUT;
   logic [NCH-1:0]    rx_ready;
   logic              BTNU;
   logic              BTND;
   logic              BTNC;
   logic [127:0]      OLED_S0;
   logic [127:0]      OLED_S1;
   logic [127:0]      OLED_S2;
   logic [127:0]      OLED_S3;
   logic [7:0]        LD;

   modport master (
      output DOUT, rx_ready, BTNU, BTND, BTNC,
      input  OLED_S0, OLED_S1, OLED_S2, OLED_S3, LD
   );

   modport slave (
      input  DOUT, rx_ready, BTNU, BTND, BTNC,
      output OLED_S0, OLED_S1, OLED_S2, OLED_S3, LD
   );
endinterface

`default_nettype wire

// File: rtl/can_node_monitor_debounce.sv
// ============================================================================
// btn_debounce : 2-FF synchroniser, DEB-sample debouncer, rising-edge pulse
// Revision 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEB = 1000
) (
   input  wire logic GCLK,
   input  wire logic RES,
   input  wire logic din,
   output logic      pulse
);
   localparam int CW = (DEB > 2) ? $clog2(DEB) : 1;

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] run;

   // run counts consecutive samples that disagree with the stable state
   always_ff @(posedge GCLK or negedge RES) begin
      if (!RES) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         run    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         pulse <= 1'b0;
         if (sync2 == stable) begin
            run <= '0;
         end else if (run == CW'(DEB - 1)) begin
            run    <= '0;
            stable <= sync2;
            pulse  <= sync2;
         end else begin
            run <= run + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/can_node_monitor.sv
// ============================================================================
// can_node_monitor : per-channel CAN snapshot/counters paged onto OLED + LEDs
// Revision 1.0
// ============================================================================
`default_nettype none

module can_node_monitor
   import can_mon_pkg::*;
#(
   parameter int NCH  = 2,
   parameter int DW   = 108,
   parameter int TICK = 100,
   parameter int DEB  = 1000
) (
   input wire logic        GCLK,
   input wire logic        RES,
   can_node_monitor_if.slave bus
);
   localparam int NPG   = (NCH + LPP - 1) / LPP;
   localparam int NSLOT = NPG * LPP;
   localparam int SW    = $clog2(NSLOT);
   localparam int TW    = $clog2(TICK);

   logic up;
   logic dn;
   logic clr;

   btn_debounce #(.DEB(DEB)) u_btnu (.GCLK(GCLK), .RES(RES), .din(bus.BTNU), .pulse(up));
   btn_debounce #(.DEB(DEB)) u_btnd (.GCLK(GCLK), .RES(RES), .din(bus.BTND), .pulse(dn));
   btn_debounce #(.DEB(DEB)) u_btnc (.GCLK(GCLK), .RES(RES), .din(bus.BTNC), .pulse(clr));

   logic [2:0] pg;

   always_ff @(posedge GCLK or negedge RES) begin
      if (!RES) begin
         pg <= 3'd0;
      end else if (up && !dn) begin
         pg <= (pg == 3'(NPG - 1)) ? 3'd0 : pg + 3'd1;
      end else if (dn && !up) begin
         pg <= (pg == 3'd0) ? 3'(NPG - 1) : pg - 3'd1;
      end
   end

   logic [TW-1:0] tcnt;
   logic          tick;

   assign tick = (tcnt == TW'(TICK - 1));

   always_ff @(posedge GCLK or negedge RES) begin
      if (!RES) begin
         tcnt <= '0;
      end else begin
         tcnt <= tick ? '0 : tcnt + 1'b1;
      end
   end

   logic [7:0]    cnt  [NCH];
   logic [DW-1:0] snap [NCH];
   logic [NCH-1:0] act;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic          rx_q;
      logic          rise;
      logic [7:0]    cnt_r;
      logic [DW-1:0] snap_r;
      logic          act_r;

      assign rise = bus.rx_ready[i] & ~rx_q;

      // a rise in the same cycle as a clear lands on top of the cleared count
      always_ff @(posedge GCLK or negedge RES) begin
         if (!RES) begin
            rx_q   <= 1'b0;
            cnt_r  <= 8'd0;
            snap_r <= '0;
            act_r  <= 1'b0;
         end else begin
            rx_q <= bus.rx_ready[i];
            if (rise) begin
               snap_r <= bus.DOUT[i*DW +: DW];
               act_r  <= 1'b1;
               if (clr)                 cnt_r <= 8'd1;
               else if (cnt_r != 8'hFF) cnt_r <= cnt_r + 8'd1;
            end else if (clr) begin
               cnt_r <= 8'd0;
               act_r <= 1'b0;
            end
         end
      end

      assign cnt[i]  = cnt_r;
      assign snap[i] = snap_r;
      assign act[i]  = act_r;
   end

   logic [7:0]    cnt_pad  [NSLOT];
   logic [DW-1:0] snap_pad [NSLOT];

   for (genvar j = 0; j < NSLOT; j++) begin : g_pad
      if (j < NCH) begin : g_real
         assign cnt_pad[j]  = cnt[j];
         assign snap_pad[j] = snap[j];
      end else begin : g_none
         assign cnt_pad[j]  = 8'd0;
         assign snap_pad[j] = '0;
      end
   end

   logic [71:0]   cells;
   logic [127:0]  line0_n;
   logic [127:0]  line_n [LPP];
   logic [SW-1:0] idx;
   logic [7:0]    ld_n;

   always_comb begin
      cells = {3{ASCII_DASH, ASCII_DASH, ASCII_SP}};
      idx   = '0;
      for (int k = 0; k < LPP; k++) begin
         line_n[k] = LINE_SP;
         if ((int'(pg) * LPP + k) < NCH) begin
            idx = SW'(int'(pg) * LPP + k);
            cells[(LPP-1-k)*24 +: 24] = {hex2ascii(cnt_pad[idx][7:4]),
                                         hex2ascii(cnt_pad[idx][3:0]), ASCII_SP};
            line_n[k] = 128'(snap_pad[idx]);
         end
      end
      line0_n = {8'h50, digit(4'(pg) + 4'd1), 8'h2F, digit(4'(NPG)), ASCII_SP,
                 cells, ASCII_SP, ASCII_SP};
   end

   for (genvar l = 0; l < 8; l++) begin : g_ld
      if (l < NCH) begin : g_on
         assign ld_n[l] = act[l];
      end else begin : g_off
         assign ld_n[l] = 1'b0;
      end
   end

   always_ff @(posedge GCLK or negedge RES) begin
      if (!RES) begin
         bus.OLED_S0 <= LINE_SP;
         bus.OLED_S1 <= LINE_SP;
         bus.OLED_S2 <= LINE_SP;
         bus.OLED_S3 <= LINE_SP;
         bus.LD      <= 8'd0;
      end else if (tick) begin
         bus.OLED_S0 <= line0_n;
         bus.OLED_S1 <= line_n[0];
         bus.OLED_S2 <= line_n[1];
         bus.OLED_S3 <= line_n[2];
         bus.LD      <= ld_n;
      end
   end

endmodule

`default_nettype wire
